table_fsm_engine: RTL and testbench



---
 rtl/table_fsm_pkg.sv | 47 ++++
 rtl/table_fsm_match.sv | 72 +++++++
 rtl/table_fsm_engine.sv | 147 ++++++++++++++
 tb/tb_table_fsm_engine.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/table_fsm_pkg.sv
// Shared sizing helpers and cfg_rule field offsets for the table-driven FSM engine.
// Rule layout, MSB first: {en, st_any, st, mask, val, nxt, out}.
package table_fsm_pkg;

    localparam int MISS_CNT_W = 16;

    function automatic int calc_sw(input int n_states);
        return (n_states > 2) ? $clog2(n_states) : 1;
    endfunction

    function automatic int calc_rw(input int n_rules);
        return (n_rules > 2) ? $clog2(n_rules) : 1;
    endfunction

    function automatic int calc_rule_w(input int sw, input int in_w, input int out_w);
        return 2 + 2 * sw + 2 * in_w + out_w;
    endfunction

    function automatic int off_out();
        return 0;
    endfunction

    function automatic int off_nxt(input int out_w);
        return out_w;
    endfunction

    function automatic int off_val(input int sw, input int out_w);
        return out_w + sw;
    endfunction

    function automatic int off_mask(input int sw, input int in_w, input int out_w);
        return out_w + sw + in_w;
    endfunction

    function automatic int off_st(input int sw, input int in_w, input int out_w);
        return out_w + sw + 2 * in_w;
    endfunction

    function automatic int off_st_any(input int sw, input int in_w, input int out_w);
        return out_w + 2 * sw + 2 * in_w;
    endfunction

    function automatic int off_en(input int sw, input int in_w, input int out_w);
        return out_w + 2 * sw + 2 * in_w + 1;
    endfunction

endpackage

// File: rtl/table_fsm_match.sv
// Combinational rule matcher: evaluates every rule against (cur_state, in_sym)
// and picks the lowest matching index with a balanced priority tree.
module table_fsm_match
    import table_fsm_pkg::*;
#(
    parameter int N_RULES = 16,
    parameter int SW      = 3,
    parameter int IN_W    = 2,
    parameter int OUT_W   = 2
) (
    input  logic [N_RULES-1:0][calc_rule_w(SW, IN_W, OUT_W)-1:0] rules,
    input  logic [SW-1:0]                                        cur_state,
    input  logic [IN_W-1:0]                                      in_sym,
    output logic                                                 hit,
    output logic [calc_rw(N_RULES)-1:0]                          hit_idx,
    output logic [SW-1:0]                                        nxt,
    output logic [OUT_W-1:0]                                     out
);

    localparam int RULE_W  = calc_rule_w(SW, IN_W, OUT_W);
    localparam int RW      = calc_rw(N_RULES);
    localparam int NP      = 1 << RW;
    localparam int O_OUT   = off_out();
    localparam int O_NXT   = off_nxt(OUT_W);
    localparam int O_VAL   = off_val(SW, OUT_W);
    localparam int O_MASK  = off_mask(SW, IN_W, OUT_W);
    localparam int O_ST    = off_st(SW, IN_W, OUT_W);
    localparam int O_ANY   = off_st_any(SW, IN_W, OUT_W);
    localparam int O_EN    = off_en(SW, IN_W, OUT_W);

    // Heap-ordered tree: node n has children 2n and 2n+1, leaves start at NP.
    logic          node_hit [2*NP];
    logic [RW-1:0] node_idx [2*NP];
    logic [RULE_W-1:0] r;
    logic [IN_W-1:0]   r_mask;

    always_comb begin
        r      = '0;
        r_mask = '0;
        for (int n = 0; n < 2 * NP; n++) begin
            node_hit[n] = 1'b0;
            node_idx[n] = '0;
        end
        for (int i = 0; i < NP; i++) begin
            node_idx[NP + i] = RW'(i);
        end
        for (int i = 0; i < N_RULES; i++) begin
            r      = rules[i];
            r_mask = r[O_MASK +: IN_W];
            node_hit[NP + i] = r[O_EN]
                && (r[O_ANY] || (r[O_ST +: SW] == cur_state))
                && ((in_sym & r_mask) == (r[O_VAL +: IN_W] & r_mask));
        end
        // Left child covers lower indices, so it wins whenever it hits.
        for (int n = NP - 1; n >= 1; n--) begin
            node_hit[n] = node_hit[2*n] | node_hit[2*n + 1];
            node_idx[n] = node_hit[2*n] ? node_idx[2*n] : node_idx[2*n + 1];
        end
        hit     = node_hit[1];
        hit_idx = node_idx[1];
    end

    always_comb begin
        nxt = '0;
        out = '0;
        if (hit) begin
            nxt = rules[hit_idx][O_NXT +: SW];
            out = rules[hit_idx][O_OUT +: OUT_W];
        end
    end

endmodule

// File: rtl/table_fsm_engine.sv
// Table-driven Mealy FSM engine: rule table, state register, config checks,
// registered output stage with full-rate valid/ready and a saturating miss counter.
module table_fsm_engine
    import table_fsm_pkg::*;
#(
    parameter int N_STATES    = 7,
    parameter int IN_W        = 2,
    parameter int OUT_W       = 2,
    parameter int N_RULES     = 16,
    parameter int RESET_STATE = 0,
    parameter int DEFAULT_OUT = 0
) (
    input  logic                                                        clk,
    input  logic                                                        rst_n,
    input  logic                                                        run,
    input  logic                                                        restart,
    input  logic                                                        cfg_we,
    input  logic [calc_rw(N_RULES)-1:0]                                 cfg_idx,
    input  logic [calc_rule_w(calc_sw(N_STATES), IN_W, OUT_W)-1:0]      cfg_rule,
    output logic                                                        cfg_err,
    input  logic                                                        in_valid,
    output logic                                                        in_ready,
    input  logic [IN_W-1:0]                                             in_sym,
    output logic                                                        out_valid,
    input  logic                                                        out_ready,
    output logic [OUT_W-1:0]                                            out_sym,
    output logic [calc_sw(N_STATES)-1:0]                                out_state,
    output logic                                                        out_miss,
    output logic [MISS_CNT_W-1:0]                                       miss_cnt
);

    localparam int SW     = calc_sw(N_STATES);
    localparam int RW     = calc_rw(N_RULES);
    localparam int RULE_W = calc_rule_w(SW, IN_W, OUT_W);
    localparam int O_NXT  = off_nxt(OUT_W);
    localparam int O_ST   = off_st(SW, IN_W, OUT_W);
    localparam int O_EN   = off_en(SW, IN_W, OUT_W);

    localparam logic [SW-1:0]         RST_ST  = SW'(RESET_STATE);
    localparam logic [OUT_W-1:0]      DEF_OUT = OUT_W'(DEFAULT_OUT);
    localparam logic [MISS_CNT_W-1:0] CNT_MAX = '1;

    logic [N_RULES-1:0][RULE_W-1:0] rule_tbl;
    logic [SW-1:0]                  cur_state;

    logic              m_hit;
    logic [RW-1:0]     m_idx;
    logic [SW-1:0]     m_nxt;
    logic [OUT_W-1:0]  m_out;

    logic          accept;
    logic          cfg_ok;
    logic          cfg_en;
    logic [SW-1:0] cfg_st;
    logic [SW-1:0] cfg_nxt;

    // Handshake: a symbol moves when in_valid && in_ready; an output moves when
    // out_valid && out_ready. The output slot frees in the same cycle it pops,
    // so accept and pop can overlap for one symbol per cycle.
    assign in_ready = run && !restart && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    table_fsm_match #(
        .N_RULES (N_RULES),
        .SW      (SW),
        .IN_W    (IN_W),
        .OUT_W   (OUT_W)
    ) u_match (
        .rules     (rule_tbl),
        .cur_state (cur_state),
        .in_sym    (in_sym),
        .hit       (m_hit),
        .hit_idx   (m_idx),
        .nxt       (m_nxt),
        .out       (m_out)
    );

    // Disabled entries never win, so the winner must have its enable set.
    hit_is_enabled: assert property (@(posedge clk) disable iff (!rst_n)
        !m_hit || rule_tbl[m_idx][O_EN]);

    // State fields of a disabled rule are don't-care and not range checked.
    always_comb begin
        cfg_en  = cfg_rule[O_EN];
        cfg_st  = cfg_rule[O_ST +: SW];
        cfg_nxt = cfg_rule[O_NXT +: SW];
        cfg_ok  = !run
            && (32'(cfg_idx) < N_RULES)
            && (!cfg_en || ((32'(cfg_st) < N_STATES) && (32'(cfg_nxt) < N_STATES)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rule_tbl <= '0;
            cfg_err  <= 1'b0;
        end else begin
            cfg_err <= cfg_we && !cfg_ok;
            if (cfg_we && cfg_ok) begin
                rule_tbl[cfg_idx] <= cfg_rule;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= RST_ST;
        end else if (restart) begin
            cur_state <= RST_ST;
        end else if (accept && m_hit) begin
            cur_state <= m_nxt;
        end
    end

    // Data fields only change on accept; a plain pop leaves them as they were.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sym   <= '0;
            out_state <= RST_ST;
            out_miss  <= 1'b0;
        end else if (restart) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            if (m_hit) begin
                out_sym   <= m_out;
                out_state <= m_nxt;
                out_miss  <= 1'b0;
            end else begin
                out_sym   <= DEF_OUT;
                out_state <= cur_state;
                out_miss  <= 1'b1;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss_cnt <= '0;
        end else if (accept && !m_hit && (miss_cnt != CNT_MAX)) begin
            miss_cnt <= miss_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_table_fsm_engine.sv
// Directed bench for table_fsm_engine: drivers push expected outputs into a
// queue and an independent monitor pops and compares on every output pop.
module tb_table_fsm_engine;

    localparam int SW     = 3;
    localparam int RW     = 4;
    localparam int IN_W   = 2;
    localparam int OUT_W  = 2;
    localparam int RULE_W = 14;
    localparam int EW     = OUT_W + SW + 1;

    logic              clk;
    logic              rst_n;
    logic              run;
    logic              restart;
    logic              cfg_we;
    logic [RW-1:0]     cfg_idx;
    logic [RULE_W-1:0] cfg_rule;
    logic              cfg_err;
    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   in_sym;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_sym;
    logic [SW-1:0]     out_state;
    logic              out_miss;
    logic [15:0]       miss_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_got;
    logic [EW-1:0] mon_want;

    table_fsm_engine dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .restart   (restart),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_rule  (cfg_rule),
        .cfg_err   (cfg_err),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sym    (in_sym),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sym   (out_sym),
        .out_state (out_state),
        .out_miss  (out_miss),
        .miss_cnt  (miss_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [RULE_W-1:0] mk_rule(input logic en, input logic any,
        input logic [2:0] st, input logic [1:0] mask, input logic [1:0] val,
        input logic [2:0] nxt, input logic [1:0] out);
        return {en, any, st, mask, val, nxt, out};
    endfunction

    function automatic logic [EW-1:0] mk_exp(input logic [1:0] o, input logic [2:0] s,
        input logic m);
        return {o, s, m};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total_cnt++;
        if (act === want) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, want);
    endtask

    // All driver tasks start and end just after a rising edge.
    task automatic cfg_write(input logic [RW-1:0] idx, input logic [RULE_W-1:0] rule,
        input logic want_err, input string name);
        cfg_we   = 1'b1;
        cfg_idx  = idx;
        cfg_rule = rule;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        @(negedge clk);
        check(name, 32'(cfg_err), 32'(want_err));
        @(posedge clk); #1;
    endtask

    task automatic send_sym(input logic [1:0] sym, input logic push, input logic [EW-1:0] want);
        logic acc;
        int   cyc;
        acc = 1'b0;
        cyc = 0;
        in_valid = 1'b1;
        in_sym   = sym;
        while (!acc && cyc < 100) begin
            @(negedge clk);
            acc = in_ready;
            if (acc && push) exp_q.push_back(want);
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        if (!acc) check("send_timeout", 32'(cyc), 32'(0));
    endtask

    task automatic drain();
        int cyc;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("drain_queue_empty", 32'(exp_q.size()), 32'(0));
    endtask

    task automatic do_restart();
        restart = 1'b1;
        @(negedge clk);
        check("in_ready_during_restart", 32'(in_ready), 32'(0));
        @(posedge clk); #1;
        restart = 1'b0;
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            total_cnt++;
            mon_got = {out_sym, out_state, out_miss};
            if (exp_q.size() == 0) begin
                $display("FAIL out_unexpected: got {sym,state,miss}=%0h, expected no output", mon_got);
            end else begin
                mon_want = exp_q.pop_front();
                if (mon_got === mon_want) pass_cnt++;
                else $display("FAIL out_data: got {sym,state,miss}=%0h, expected %0h", mon_got, mon_want);
            end
        end
    end

    logic [1:0]    bp_sym [6];
    logic [EW-1:0] bp_exp [6];

    initial begin
        int  idx;
        int  acc;
        int  cyc;
        logic a;

        rst_n = 1'b0; run = 1'b0; restart = 1'b0; cfg_we = 1'b0;
        cfg_idx = '0; cfg_rule = '0; in_valid = 1'b0; in_sym = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // reset / idle
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_sym",   32'(out_sym),   32'(0));
        check("rst_out_state", 32'(out_state), 32'(0));
        check("rst_out_miss",  32'(out_miss),  32'(0));
        check("rst_miss_cnt",  32'(miss_cnt),  32'(0));
        check("rst_cfg_err",   32'(cfg_err),   32'(0));
        check("idle_in_ready_run0", 32'(in_ready), 32'(0));
        @(posedge clk); #1;
        run = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        check("idle_in_ready_run1", 32'(in_ready), 32'(1));
        @(posedge clk); #1;

        // miss on empty table
        send_sym(2'd0, 1'b1, mk_exp(2'd0, 3'd0, 1'b1));
        send_sym(2'd1, 1'b1, mk_exp(2'd0, 3'd0, 1'b1));
        send_sym(2'd3, 1'b1, mk_exp(2'd0, 3'd0, 1'b1));
        drain();
        check("miss_cnt_after_3", 32'(miss_cnt), 32'(3));

        // basic transitions
        run = 1'b0;
        cfg_write(4'd0, mk_rule(1, 0, 3'd0, 2'd3, 2'd1, 3'd2, 2'd1), 1'b0, "cfg_err_rule0");
        cfg_write(4'd1, mk_rule(1, 0, 3'd2, 2'd0, 2'd0, 3'd5, 2'd3), 1'b0, "cfg_err_rule1");
        run = 1'b1;
        send_sym(2'd1, 1'b1, mk_exp(2'd1, 3'd2, 1'b0));
        send_sym(2'd0, 1'b1, mk_exp(2'd3, 3'd5, 1'b0));
        send_sym(2'd2, 1'b1, mk_exp(2'd0, 3'd5, 1'b1));
        drain();

        // write while running is rejected; a catch-all rule there would have matched
        cfg_write(4'd2, mk_rule(1, 1, 3'd0, 2'd0, 2'd0, 3'd0, 2'd2), 1'b1, "cfg_err_run1");
        send_sym(2'd0, 1'b1, mk_exp(2'd0, 3'd5, 1'b1));
        drain();
        check("miss_cnt_after_5", 32'(miss_cnt), 32'(5));

        // restart returns to state 0 and discards the pending output
        do_restart();
        out_ready = 1'b0;
        send_sym(2'd1, 1'b0, '0);
        @(negedge clk);
        check("pending_out_valid", 32'(out_valid), 32'(1));
        @(posedge clk); #1;
        do_restart();
        @(negedge clk);
        check("restart_drops_valid", 32'(out_valid), 32'(0));
        @(posedge clk); #1;
        out_ready = 1'b1;
        send_sym(2'd1, 1'b1, mk_exp(2'd1, 3'd2, 1'b0));
        drain();

        // priority / wildcard
        run = 1'b0;
        do_restart();
        cfg_write(4'd0, mk_rule(1, 1, 3'd0, 2'd2, 2'd2, 3'd4, 2'd2), 1'b0, "cfg_err_prio0");
        cfg_write(4'd3, mk_rule(1, 0, 3'd0, 2'd3, 2'd3, 3'd6, 2'd3), 1'b0, "cfg_err_prio3");
        run = 1'b1;
        send_sym(2'd3, 1'b1, mk_exp(2'd2, 3'd4, 1'b0));
        send_sym(2'd1, 1'b1, mk_exp(2'd0, 3'd4, 1'b1));
        send_sym(2'd2, 1'b1, mk_exp(2'd2, 3'd4, 1'b0));
        drain();

        // range checks on enabled rules; disabled rules skip them
        run = 1'b0;
        cfg_write(4'd2, mk_rule(1, 1, 3'd0, 2'd0, 2'd0, 3'd7, 2'd1), 1'b1, "cfg_err_nxt7");
        cfg_write(4'd2, mk_rule(1, 0, 3'd7, 2'd0, 2'd0, 3'd0, 2'd1), 1'b1, "cfg_err_st7");
        cfg_write(4'd4, mk_rule(0, 1, 3'd7, 2'd0, 2'd0, 3'd7, 2'd1), 1'b0, "cfg_err_disabled");
        run = 1'b1;

        // back-pressure then full-rate release, state 4
        bp_sym = '{2'd2, 2'd0, 2'd3, 2'd1, 2'd2, 2'd0};
        for (int i = 0; i < 6; i++) begin
            bp_exp[i] = (bp_sym[i][1]) ? mk_exp(2'd2, 3'd4, 1'b0) : mk_exp(2'd0, 3'd4, 1'b1);
        end
        out_ready = 1'b0;
        idx = 0; acc = 0;
        in_valid = 1'b1; in_sym = bp_sym[0];
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            a = in_valid && in_ready;
            if (a) begin exp_q.push_back(bp_exp[idx]); idx++; acc++; end
            @(posedge clk); #1;
            if (a) begin
                if (idx < 6) in_sym = bp_sym[idx];
                else in_valid = 1'b0;
            end
        end
        check("bp_accepts_while_stalled", 32'(acc), 32'(1));
        out_ready = 1'b1;
        cyc = 0;
        while (idx < 6 && cyc < 50) begin
            @(negedge clk);
            a = in_valid && in_ready;
            if (a) begin exp_q.push_back(bp_exp[idx]); idx++; end
            @(posedge clk); #1;
            cyc++;
            if (a && idx < 6) in_sym = bp_sym[idx];
        end
        in_valid = 1'b0;
        check("bp_release_cycles", 32'(cyc), 32'(5));
        drain();
        check("miss_cnt_final", 32'(miss_cnt), 32'(9));
        repeat (2) @(posedge clk);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
